// File: rtl/bp_gshare_btb_pkg.sv
// Shared types and constants for the gshare/bimodal branch predictor with BTB.
// Entry struct uses the default widths; bp_gshare_btb passes a width-matched twin to bp_btb.
package bp_pkg;

  typedef enum logic {
    BP_BIMODAL = 1'b0,
    BP_GSHARE  = 1'b1
  } bp_mode_e;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } bp_state_e;

  typedef logic [1:0] bp_cnt_t;

  localparam int unsigned BP_XLEN_DEF  = 32;
  localparam int unsigned BP_TAG_W_DEF = 8;

  typedef struct packed {
    logic                    valid;
    logic [BP_TAG_W_DEF-1:0] tag;
    logic [BP_XLEN_DEF-1:0]  target;
  } bp_btb_entry_t;

  localparam bp_cnt_t BP_CNT_INIT = 2'b01;

  function automatic bp_cnt_t bp_cnt_next(input bp_cnt_t c, input logic taken);
    if (taken) return (c == 2'b11) ? c : c + 2'b01;
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

endpackage

// File: rtl/bp_gshare_btb_if.sv
// Prediction request/response and branch resolution bus between IFU/EXU and predictor.
interface bp_gshare_btb_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned GHR_W = 6
);
  logic             lookup_valid;
  logic [XLEN-1:0]  lookup_pc;
  logic             pred_valid;
  logic             pred_taken;
  logic [XLEN-1:0]  pred_target;
  logic [GHR_W-1:0] pred_ghr;
  logic             upd_valid;
  logic [XLEN-1:0]  upd_pc;
  logic             upd_taken;
  logic [XLEN-1:0]  upd_target;
  logic [GHR_W-1:0] upd_ghr;
  logic             upd_mispredict;
  logic             ready;

  modport master (
    output lookup_valid, lookup_pc,
    output upd_valid, upd_pc, upd_taken, upd_target, upd_ghr, upd_mispredict,
    input  pred_valid, pred_taken, pred_target, pred_ghr, ready
  );

  modport slave (
    input  lookup_valid, lookup_pc,
    input  upd_valid, upd_pc, upd_taken, upd_target, upd_ghr, upd_mispredict,
    output pred_valid, pred_taken, pred_target, pred_ghr, ready
  );
endinterface

// File: rtl/bp_gshare_btb_btb.sv
// Branch target buffer array: valid/tag/target per index, async read, one sync write port.
module bp_btb
  import bp_pkg::*;
#(
    parameter int unsigned IDX_W   = 6,
    parameter type         entry_t = bp_btb_entry_t
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] raddr,
    output entry_t           rdata,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  entry_t           wdata
);

  entry_t mem [2**IDX_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/bp_gshare_btb.sv
// Gshare/bimodal direction predictor with BTB: 2-bit counters, speculative GHR,
// init sweep after reset, one-cycle registered prediction.
module bp_gshare_btb
  import bp_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned IDX_W = 6,
    parameter int unsigned TAG_W = 8,
    parameter int unsigned GHR_W = 6,
    parameter bp_mode_e    MODE  = BP_GSHARE
) (
    input logic            clk,
    input logic            rst_n,
    bp_gshare_btb_if.slave bus
);

  localparam int unsigned ENTRIES = 2**IDX_W;
  localparam int unsigned HIST_W  = (GHR_W < IDX_W) ? GHR_W : IDX_W;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  target;
  } entry_t;

  // History folded into the index: zero-extended or truncated; ignored in bimodal mode.
  function automatic logic [IDX_W-1:0] fold_hist(input logic [GHR_W-1:0] g);
    logic [IDX_W-1:0] h;
    h = '0;
    if (MODE == BP_GSHARE) h[HIST_W-1:0] = g[HIST_W-1:0];
    return h;
  endfunction

  bp_state_e        state_q, state_d;
  logic [IDX_W-1:0] init_idx_q, init_idx_d;
  logic [GHR_W-1:0] ghr_q, ghr_d;
  bp_cnt_t          cnt_q [ENTRIES];

  logic             pred_valid_q, pred_taken_q;
  logic [XLEN-1:0]  pred_target_q;
  logic [GHR_W-1:0] pred_ghr_q;

  logic             look_acc, upd_acc, look_hit, look_taken, btb_we;
  logic [IDX_W-1:0] look_idx, upd_idx, btb_waddr;
  logic [TAG_W-1:0] look_tag, upd_tag;
  logic [XLEN-1:0]  look_target;
  entry_t           look_entry, btb_wdata;
  logic             unused_upd_pc_bits;

  assign look_acc = (state_q == READY) && bus.lookup_valid;
  assign upd_acc  = (state_q == READY) && bus.upd_valid;

  assign look_idx = bus.lookup_pc[IDX_W+1:2] ^ fold_hist(ghr_q);
  assign upd_idx  = bus.upd_pc[IDX_W+1:2] ^ fold_hist(bus.upd_ghr);
  assign look_tag = bus.lookup_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign upd_tag  = bus.upd_pc[IDX_W+TAG_W+1:IDX_W+2];

  assign unused_upd_pc_bits = ^{bus.upd_pc[XLEN-1:IDX_W+TAG_W+2], bus.upd_pc[1:0]};

  bp_btb #(
    .IDX_W   (IDX_W),
    .entry_t (entry_t)
  ) u_btb (
    .clk   (clk),
    .raddr (look_idx),
    .rdata (look_entry),
    .we    (btb_we),
    .waddr (btb_waddr),
    .wdata (btb_wdata)
  );

  assign look_hit    = look_entry.valid && (look_entry.tag == look_tag);
  assign look_taken  = look_hit && cnt_q[look_idx][1];
  assign look_target = look_taken ? look_entry.target : bus.lookup_pc + XLEN'(4);

  // The sweep owns the BTB write port until READY; afterwards only taken updates write.
  always_comb begin
    btb_we    = 1'b0;
    btb_waddr = upd_idx;
    btb_wdata = '0;
    if (rst_n) begin
      if (state_q == INIT) begin
        btb_we    = 1'b1;
        btb_waddr = init_idx_q;
      end else if (upd_acc && bus.upd_taken) begin
        btb_we    = 1'b1;
        btb_wdata = '{valid: 1'b1, tag: upd_tag, target: bus.upd_target};
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    case (state_q)
      INIT: begin
        init_idx_d = init_idx_q + 1'b1;
        if (init_idx_q == '1) state_d = READY;
      end
      READY: ;
      default: state_d = INIT;
    endcase
  end

  // A mispredict repair takes priority over the speculative shift of the same cycle.
  always_comb begin
    ghr_d = ghr_q;
    if (look_acc) ghr_d = {ghr_q[GHR_W-2:0], look_taken};
    if (upd_acc && bus.upd_mispredict) ghr_d = {bus.upd_ghr[GHR_W-2:0], bus.upd_taken};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= INIT;
      init_idx_q    <= '0;
      ghr_q         <= '0;
      pred_valid_q  <= 1'b0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= '0;
      pred_ghr_q    <= '0;
    end else begin
      state_q      <= state_d;
      init_idx_q   <= init_idx_d;
      ghr_q        <= ghr_d;
      pred_valid_q <= look_acc;
      if (look_acc) begin
        pred_taken_q  <= look_taken;
        pred_target_q <= look_target;
        pred_ghr_q    <= ghr_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state_q == INIT) cnt_q[init_idx_q] <= BP_CNT_INIT;
      else if (upd_acc) cnt_q[upd_idx] <= bp_cnt_next(cnt_q[upd_idx], bus.upd_taken);
    end
  end

  assign bus.pred_valid  = pred_valid_q;
  assign bus.pred_taken  = pred_taken_q;
  assign bus.pred_target = pred_target_q;
  assign bus.pred_ghr    = pred_ghr_q;
  assign bus.ready       = (state_q == READY);

endmodule

// File: tb/tb_bp_gshare_btb.sv
// Bench for bp_gshare_btb: one bimodal and one gshare instance on a shared clock/reset,
// expected predictions queued at lookup time and compared when pred_valid appears.
module tb_bp_gshare_btb;
  import bp_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bp_gshare_btb_if #(.XLEN(32), .GHR_W(6)) bif ();
  bp_gshare_btb_if #(.XLEN(32), .GHR_W(6)) gif ();

  bp_gshare_btb #(.XLEN(32), .IDX_W(6), .TAG_W(8), .GHR_W(6), .MODE(BP_BIMODAL)) dut_bim (
    .clk (clk), .rst_n (rst_n), .bus (bif)
  );
  bp_gshare_btb #(.XLEN(32), .IDX_W(6), .TAG_W(8), .GHR_W(6), .MODE(BP_GSHARE)) dut_gs (
    .clk (clk), .rst_n (rst_n), .bus (gif)
  );

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
    logic [5:0]  ghr;
  } exp_t;

  exp_t q_b[$];
  exp_t q_g[$];
  int   checks = 0;
  int   errors = 0;

  task automatic set_lookup(input bit gs, input bit v, input logic [31:0] pc);
    if (gs) begin gif.lookup_valid = v; gif.lookup_pc = pc; end
    else    begin bif.lookup_valid = v; bif.lookup_pc = pc; end
  endtask

  task automatic set_upd(input bit gs, input bit v, input logic [31:0] pc, input bit taken,
                         input logic [31:0] tgt, input logic [5:0] ghr, input bit mp);
    if (gs) begin
      gif.upd_valid = v; gif.upd_pc = pc; gif.upd_taken = taken;
      gif.upd_target = tgt; gif.upd_ghr = ghr; gif.upd_mispredict = mp;
    end else begin
      bif.upd_valid = v; bif.upd_pc = pc; bif.upd_taken = taken;
      bif.upd_target = tgt; bif.upd_ghr = ghr; bif.upd_mispredict = mp;
    end
  endtask

  task automatic upd_pulse(input bit gs, input logic [31:0] pc, input bit taken,
                           input logic [31:0] tgt, input logic [5:0] ghr, input bit mp);
    set_upd(gs, 1'b1, pc, taken, tgt, ghr, mp);
    @(negedge clk);
    set_upd(gs, 1'b0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic wait_ready(input string name);
    int  n = 0;
    bit  pv_seen = 1'b0;
    do begin
      @(posedge clk); #1; n++;
      if (gif.pred_valid || bif.pred_valid) pv_seen = 1'b1;
    end while (!(gif.ready && bif.ready) && n < 200);
    set_lookup(1'b1, 1'b0, '0); set_lookup(1'b0, 1'b0, '0);
    set_upd(1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b0); set_upd(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0);
    checks++;
    if (n !== 64) begin
      errors++; $display("FAIL %s_sweep_len: got %0d cycles to ready, want 64", name, n);
    end
    checks++;
    if (pv_seen !== 1'b0) begin
      errors++; $display("FAIL %s_init_ignored: pred_valid seen=%0b during sweep, want 0", name, pv_seen);
    end
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string name);
    checks++;
    if ({gif.ready, gif.pred_valid, gif.pred_taken, gif.pred_target, gif.pred_ghr, bif.ready, bif.pred_valid}
        !== '0) begin
      errors++;
      $display("FAIL %s: got rdy=%0b v=%0b t=%0b tgt=%h ghr=%b brdy=%0b bv=%0b, want all 0", name,
               gif.ready, gif.pred_valid, gif.pred_taken, gif.pred_target, gif.pred_ghr,
               bif.ready, bif.pred_valid);
    end
  endtask

  task automatic test_reset;
    exp_t e;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset_values");
    // lookups and updates held active through the sweep must be ignored
    set_lookup(1'b1, 1'b1, 32'h100); set_lookup(1'b0, 1'b1, 32'h100);
    set_upd(1'b1, 1'b1, 32'h100, 1'b1, 32'h900, 6'd0, 1'b1);
    set_upd(1'b0, 1'b1, 32'h100, 1'b1, 32'h900, 6'd0, 1'b1);
    rst_n = 1'b1;
    wait_ready("reset");
    set_lookup(1'b1, 1'b1, 32'h100); q_g.push_back('{1'b0, 32'h104, 6'd0});
    @(negedge clk); set_lookup(1'b1, 1'b0, '0);
    e = q_g.pop_front(); checks++;
    if ({gif.pred_valid, gif.pred_taken, gif.pred_target, gif.pred_ghr} !== {1'b1, e.taken, e.target, e.ghr}) begin
      errors++; $display("FAIL first_lookup: got v=%0b t=%0b tgt=%h ghr=%b, want v=1 t=%0b tgt=%h ghr=%b",
        gif.pred_valid, gif.pred_taken, gif.pred_target, gif.pred_ghr, e.taken, e.target, e.ghr);
    end
    @(negedge clk); checks++;
    if (gif.pred_valid !== 1'b0) begin
      errors++; $display("FAIL pred_valid_pulse: got %0b, want 0", gif.pred_valid);
    end
  endtask

  task automatic test_bimodal;
    exp_t        e;
    string       nm [6] = '{"bim_train", "bim_sat_dec", "bim_sat_floor", "bim_recover", "bim_tag_miss", "bim_pc_wrap"};
    logic [31:0] pcs [6] = '{32'h200, 32'h200, 32'h200, 32'h200, 32'h4200, 32'hFFFF_FFFC};
    for (int k = 0; k < 6; k++) begin
      case (k)
        0: begin
          repeat (2) upd_pulse(1'b0, 32'h200, 1'b1, 32'h400, 6'd0, 1'b0);
          q_b.push_back('{1'b1, 32'h400, 6'd0});
        end
        1: begin
          repeat (5) upd_pulse(1'b0, 32'h200, 1'b1, 32'h400, 6'd0, 1'b0);
          repeat (2) upd_pulse(1'b0, 32'h200, 1'b0, 32'h0, 6'd0, 1'b0);
          q_b.push_back('{1'b0, 32'h204, 6'd0});
        end
        2: begin
          repeat (2) upd_pulse(1'b0, 32'h200, 1'b0, 32'h0, 6'd0, 1'b0);
          upd_pulse(1'b0, 32'h200, 1'b1, 32'h400, 6'd0, 1'b0);
          q_b.push_back('{1'b0, 32'h204, 6'd0});
        end
        3: begin
          upd_pulse(1'b0, 32'h200, 1'b1, 32'h400, 6'd0, 1'b0);
          q_b.push_back('{1'b1, 32'h400, 6'd0});
        end
        4: q_b.push_back('{1'b0, 32'h4204, 6'd0});
        default: q_b.push_back('{1'b0, 32'h0, 6'd0});
      endcase
      set_lookup(1'b0, 1'b1, pcs[k]);
      @(negedge clk); set_lookup(1'b0, 1'b0, '0);
      e = q_b.pop_front(); checks++;
      if ({bif.pred_valid, bif.pred_taken, bif.pred_target} !== {1'b1, e.taken, e.target}) begin
        errors++; $display("FAIL %s: got v=%0b t=%0b tgt=%h, want v=1 t=%0b tgt=%h",
          nm[k], bif.pred_valid, bif.pred_taken, bif.pred_target, e.taken, e.target);
      end
    end
  endtask

  task automatic test_mispredict_ghr;
    exp_t e;
    upd_pulse(1'b1, 32'h300, 1'b1, 32'h800, 6'b000101, 1'b1);
    set_lookup(1'b1, 1'b1, 32'h300); q_g.push_back('{1'b0, 32'h304, 6'b001011});
    @(negedge clk); set_lookup(1'b1, 1'b0, '0);
    e = q_g.pop_front(); checks++;
    if ({gif.pred_valid, gif.pred_taken, gif.pred_target, gif.pred_ghr} !== {1'b1, e.taken, e.target, e.ghr}) begin
      errors++; $display("FAIL gs_mispredict_ghr: got v=%0b t=%0b tgt=%h ghr=%b, want v=1 t=%0b tgt=%h ghr=%b",
        gif.pred_valid, gif.pred_taken, gif.pred_target, gif.pred_ghr, e.taken, e.target, e.ghr);
    end
  endtask

  task automatic test_same_index;
    exp_t  e;
    string nm [3] = '{"gs_same_cycle_old", "gs_ghr_override", "gs_same_cycle_new"};
    upd_pulse(1'b1, 32'h1000, 1'b1, 32'h2000, 6'b000010, 1'b1);
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: begin
          set_upd(1'b1, 1'b1, 32'h300, 1'b0, 32'hDEAD0, 6'b000101, 1'b0);
          set_lookup(1'b1, 1'b1, 32'h300); q_g.push_back('{1'b1, 32'h800, 6'b000101});
        end
        1: begin
          set_upd(1'b1, 1'b1, 32'h1000, 1'b1, 32'h2000, 6'b000010, 1'b1);
          set_lookup(1'b1, 1'b1, 32'h400); q_g.push_back('{1'b0, 32'h404, 6'b001011});
        end
        default: begin
          set_lookup(1'b1, 1'b1, 32'h300); q_g.push_back('{1'b0, 32'h304, 6'b000101});
        end
      endcase
      @(negedge clk);
      set_lookup(1'b1, 1'b0, '0); set_upd(1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b0);
      e = q_g.pop_front(); checks++;
      if ({gif.pred_valid, gif.pred_taken, gif.pred_target, gif.pred_ghr} !== {1'b1, e.taken, e.target, e.ghr}) begin
        errors++; $display("FAIL %s: got v=%0b t=%0b tgt=%h ghr=%b, want v=1 t=%0b tgt=%h ghr=%b", nm[k],
          gif.pred_valid, gif.pred_taken, gif.pred_target, gif.pred_ghr, e.taken, e.target, e.ghr);
      end
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    set_lookup(1'b1, 1'b1, 32'h500); q_g.push_back('{1'b0, 32'h504, 6'b001010});
    @(negedge clk);
    set_lookup(1'b1, 1'b1, 32'h600); q_g.push_back('{1'b0, 32'h604, 6'b010100});
    for (int k = 0; k < 2; k++) begin
      e = q_g.pop_front(); checks++;
      if ({gif.pred_valid, gif.pred_taken, gif.pred_target, gif.pred_ghr} !== {1'b1, e.taken, e.target, e.ghr}) begin
        errors++; $display("FAIL b2b_%0d: got v=%0b t=%0b tgt=%h ghr=%b, want v=1 t=%0b tgt=%h ghr=%b", k,
          gif.pred_valid, gif.pred_taken, gif.pred_target, gif.pred_ghr, e.taken, e.target, e.ghr);
      end
      @(negedge clk); set_lookup(1'b1, 1'b0, '0);
    end
    checks++;
    if (gif.pred_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_idle: got pred_valid=%0b, want 0", gif.pred_valid);
    end
  endtask

  task automatic test_spec_taken_shift;
    exp_t        e;
    logic [31:0] pcs [2] = '{32'h1000, 32'h700};
    upd_pulse(1'b1, 32'h5000, 1'b0, 32'h0, 6'b000001, 1'b1);
    q_g.push_back('{1'b1, 32'h2000, 6'b000010});
    q_g.push_back('{1'b0, 32'h704, 6'b000101});
    for (int k = 0; k < 2; k++) begin
      set_lookup(1'b1, 1'b1, pcs[k]);
      @(negedge clk); set_lookup(1'b1, 1'b0, '0);
      e = q_g.pop_front(); checks++;
      if ({gif.pred_valid, gif.pred_taken, gif.pred_target, gif.pred_ghr} !== {1'b1, e.taken, e.target, e.ghr}) begin
        errors++; $display("FAIL spec_shift_%0d: got v=%0b t=%0b tgt=%h ghr=%b, want v=1 t=%0b tgt=%h ghr=%b", k,
          gif.pred_valid, gif.pred_taken, gif.pred_target, gif.pred_ghr, e.taken, e.target, e.ghr);
      end
    end
  endtask

  task automatic test_reset_restart;
    exp_t e;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("rerst_values");
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) @(negedge clk);
    checks++;
    if (gif.ready !== 1'b0) begin
      errors++; $display("FAIL mid_sweep_ready: got %0b, want 0", gif.ready);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready("restart");
    set_lookup(1'b0, 1'b1, 32'h200); q_b.push_back('{1'b0, 32'h204, 6'd0});
    @(negedge clk); set_lookup(1'b0, 1'b0, '0);
    e = q_b.pop_front(); checks++;
    if ({bif.pred_valid, bif.pred_taken, bif.pred_target} !== {1'b1, e.taken, e.target}) begin
      errors++; $display("FAIL restart_wiped: got v=%0b t=%0b tgt=%h, want v=1 t=%0b tgt=%h",
        bif.pred_valid, bif.pred_taken, bif.pred_target, e.taken, e.target);
    end
  endtask

  initial begin
    set_lookup(1'b1, 1'b0, '0); set_lookup(1'b0, 1'b0, '0);
    set_upd(1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b0); set_upd(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0);
    test_reset;
    test_bimodal;
    test_mispredict_ghr;
    test_same_index;
    test_back_to_back;
    test_spec_taken_shift;
    test_reset_restart;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bp_gshare_btb.md
BP_GSHARE_BTB -- requirements
Module: bp_gshare_btb

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath/PC width.
REQ-002 SHALL have parameter IDX_W, default 6, table index width (2**IDX_W entries).
REQ-003 SHALL have parameter TAG_W, default 8, BTB tag width taken from PC bits above the index.
REQ-004 SHALL have parameter GHR_W, default 6, global history width.
REQ-005 SHALL have parameter MODE, default BP_GSHARE, selecting BP_BIMODAL (no history) or BP_GSHARE.
REQ-006 One clock; reset is synchronous and active-low: clk  in  1  sole clock, all state on rising edge.
REQ-007 rst_n  in  1  synchronous active-low reset.
REQ-008 lookup_valid  in  1, lookup_pc  in  XLEN  IFU prediction request.
REQ-009 pred_valid  out  1, pred_taken  out  1, pred_target  out  XLEN, pred_ghr  out  GHR_W  prediction and history snapshot.
REQ-010 upd_valid  in  1, upd_pc  in  XLEN, upd_taken  in  1, upd_target  in  XLEN, upd_ghr  in  GHR_W, upd_mispredict  in  1  EXU resolution.
REQ-011 ready  out  1  table initialisation complete.

Function
REQ-012 FSM states INIT, READY; INIT sweeps one index per cycle from 0, writing counter=2'b01, valid=0; after index 2**IDX_W-1 SHALL enter READY.
REQ-013 ready SHALL be 0 in INIT, 1 in READY; lookups and updates SHALL be ignored in INIT (pred_valid=0).
REQ-014 Index = lookup_pc[IDX_W+1:2] XOR hist, hist = 0 in BP_BIMODAL, GHR zero-extended or truncated to IDX_W in BP_GSHARE.
REQ-015 Tag = pc[IDX_W+TAG_W+1:IDX_W+2]; hit = valid AND tag match.
REQ-016 Latency one cycle: pred_* registered; pred_valid high exactly the cycle after an accepted lookup_valid.
REQ-017 pred_taken = hit AND counter[1]; pred_target = stored target if pred_taken else lookup_pc+4 (modulo 2**XLEN).
REQ-018 pred_ghr SHALL equal the GHR used to form the index.
REQ-019 Accepted lookup SHALL shift GHR speculatively: GHR <= {GHR[GHR_W-2:0], pred_taken value}.
REQ-020 Update index SHALL use upd_pc and upd_ghr with REQ-014 rules.
REQ-021 Counter 2-bit saturating: taken increments to max 3, not-taken decrements to min 0.
REQ-022 upd_taken=1 SHALL write tag, upd_target, valid=1; upd_taken=0 SHALL leave BTB entry unchanged.
REQ-023 upd_mispredict=1 SHALL set GHR <= {upd_ghr[GHR_W-2:0], upd_taken}, overriding a same-cycle speculative shift.
REQ-024 Same-cycle lookup and update to one index: lookup SHALL read pre-update contents; update visible next cycle.

Reset
REQ-025 rst_n low at any edge SHALL force INIT, sweep index 0, GHR=0, pred_valid=0, pred_taken=0, pred_target=0, pred_ghr=0, ready=0.
REQ-026 Reset during the sweep SHALL restart the sweep from index 0.

Structure
REQ-027 Shared package bp_pkg SHALL hold bp_mode_e (BP_BIMODAL, BP_GSHARE), bp_cnt_t (2-bit), bp_btb_entry_t (valid, tag, target), constant BP_CNT_INIT=2'b01.
REQ-028 One sub-module bp_btb SHALL hold the tag/target/valid array: async read, one synchronous write port.
REQ-029 Counters, GHR, FSM SHALL live in bp_gshare_btb.

Verification
REQ-030 Reset release: ready=0 for 64 cycles, ready=1 on cycle 65; lookup 0x100 -> pred_taken=0, pred_target=0x104.
REQ-031 MODE=BP_BIMODAL: two taken updates pc 0x200 target 0x400 -> lookup 0x200 gives pred_taken=1, pred_target=0x400.
REQ-032 Five taken then two not-taken updates pc 0x200 -> counter 3 then 1 -> lookup pred_taken=0, pred_target=0x204.
REQ-033 MODE=BP_GSHARE: upd_mispredict=1, upd_ghr=6'b000101, upd_taken=1 -> next lookup pred_ghr=6'b001011.
REQ-034 Lookup and not-taken update to same index, counter 2 -> pred_taken=1 that cycle, pred_taken=0 on next lookup.
REQ-035 rst_n low at sweep cycle 20 -> ready stays 0, a full 64 further cycles after release before ready=1.
